// File: rtl/nbcac_encoder_arbiter.sv
// Shares one 19-bit -> 27-bit NBCAC encoder among N_REQ requesters using round-robin
// arbitration with an optional burst lock and a single registered valid/ready output stage.

module nbcac_19di_encoder_core (
  input  logic [18:0] datain,
  output logic [27:1] codeout
);
  // Odd data bits up to bit 15 are doubled onto adjacent wires, so every 3-wire
  // group is one single bit plus one duplicated pair; bits 16..18 pass straight.
  always_comb begin
    codeout = '0;
    for (int j = 0; j < 8; j++) begin
      codeout[3*j+1] = datain[2*j];
      codeout[3*j+2] = datain[2*j+1];
      codeout[3*j+3] = datain[2*j+1];
    end
    codeout[25] = datain[16];
    codeout[26] = datain[17];
    codeout[27] = datain[18];
  end
endmodule

module nbcac_encoder_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int SRC_W     = 2,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*19-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 code_valid,
  input  logic                 code_ready,
  output logic [27:1]          codeout,
  output logic [SRC_W-1:0]     code_src,
  output logic                 busy,
  output logic                 state_dbg,
  output logic [SRC_W-1:0]     rr_ptr_dbg,
  output logic [SRC_W-1:0]     owner_dbg,
  output logic [CNT_W-1:0]     burst_cnt_dbg
);

  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [SRC_W-1:0] owner, owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             accept;
  logic             hs;
  logic             found;
  logic [N_REQ-1:0] grant;
  logic [SRC_W-1:0] win;
  logic [18:0]      win_data;
  logic [27:1]      core_out;

  function automatic logic [SRC_W-1:0] inc_mod(input logic [SRC_W-1:0] v);
    return (int'(v) == N_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  // Handshakes: a word moves on a rising edge when valid and ready are both high
  // in the cycle before it; the output slot frees (accept) when empty or draining.
  assign accept    = ~code_valid | code_ready;
  assign req_ready = accept ? grant : '0;
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    if (state == HOLD) begin
      if (req_valid[owner]) begin
        grant[owner] = 1'b1;
        win          = owner;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
          found                                  = 1'b1;
          grant[(int'(rr_ptr) + k) % N_REQ]      = 1'b1;
          win                                    = SRC_W'((int'(rr_ptr) + k) % N_REQ);
        end
      end
    end
  end

  assign win_data = req_data[int'(win)*19 +: 19];

  nbcac_19di_encoder_core u_core (
    .datain  (win_data),
    .codeout (core_out)
  );

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    case (state)
      ARB: begin
        if (hs) begin
          if (MAX_BURST == 1) begin
            rr_ptr_nxt = inc_mod(win);
          end else begin
            owner_nxt     = win;
            burst_cnt_nxt = CNT_W'(1);
            state_nxt     = HOLD;
          end
        end
      end
      HOLD: begin
        // With accept low everything is frozen; with accept high an idle owner
        // gives up the lock and that cycle grants nobody.
        if (accept) begin
          if (hs && (int'(burst_cnt) + 1 != MAX_BURST)) begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end else begin
            rr_ptr_nxt    = inc_mod(owner);
            burst_cnt_nxt = '0;
            state_nxt     = ARB;
          end
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // codeout/code_src are only written on a load, so an idle link keeps its last word.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      codeout    <= '0;
      code_src   <= '0;
      code_valid <= 1'b0;
    end else if (hs) begin
      codeout    <= core_out;
      code_src   <= win;
      code_valid <= 1'b1;
    end else if (code_ready) begin
      code_valid <= 1'b0;
    end
  end

  assign busy          = (state == HOLD) | code_valid;
  assign state_dbg     = (state == HOLD);
  assign rr_ptr_dbg    = rr_ptr;
  assign owner_dbg     = owner;
  assign burst_cnt_dbg = burst_cnt;

endmodule
